// File: rtl/param_file_register_if.sv
// Bus bundle for param_file_register: control, addresses, write data and read/handshake outputs.
interface param_file_register_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             clr;
  logic             clr_all;
  logic             load;
  logic [AW-1:0]    addr_a;
  logic [AW-1:0]    addr_b;
  logic [WIDTH-1:0] d_in;
  logic             mb_select;
  logic [WIDTH-1:0] val_a;
  logic [WIDTH-1:0] val_b;
  logic             busy;
  logic             done;

  modport master (
    output clr, clr_all, load, addr_a, addr_b, d_in, mb_select,
    input  val_a, val_b, busy, done
  );

  modport slave (
    input  clr, clr_all, load, addr_a, addr_b, d_in, mb_select,
    output val_a, val_b, busy, done
  );
endinterface

// File: rtl/param_file_register.sv
// DEPTH x WIDTH register file, two combinational read ports, clear-all sweep FSM.
// Define FR_BYPASS_EN for write-through forwarding of d_in onto the read ports.
//
// state | meaning
// IDLE  | accepts clr_all > clr > load on each edge
// SWEEP | clears reg[cnt] per edge; load/clr/clr_all dropped
module param_file_register #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int ZERO_REG = 0
) (
  input logic                  clk,
  input logic                  reset,
  param_file_register_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [WIDTH-1:0] rd_a, rd_b, imm_b;

  // Address decode: out-of-range addresses and a hard-wired reg 0 never match.
  function automatic logic hit(input logic [AW-1:0] a, input int i);
    return (a == AW'(i)) && !((ZERO_REG != 0) && (i == 0));
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    regs_d  = regs_q;
    case (state_q)
      IDLE: begin
        if (bus.clr_all) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end else if (bus.clr || bus.load) begin
          for (int i = 0; i < DEPTH; i++)
            if (hit(bus.addr_a, i)) regs_d[i] = bus.clr ? '0 : bus.d_in;
        end
      end
      SWEEP: begin
        for (int i = 0; i < DEPTH; i++)
          if (cnt_q == AW'(i)) regs_d[i] = '0;
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (hit(bus.addr_a, i)) rd_a = regs_q[i];
      if (hit(bus.addr_b, i)) rd_b = regs_q[i];
    end
  end

  assign imm_b = WIDTH'(bus.addr_b);

`ifdef FR_BYPASS_EN
  logic fwd;

  // Forward only when this edge will really commit d_in to addr_a.
  always_comb begin
    fwd = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (hit(bus.addr_a, i))
        fwd = (state_q == IDLE) && bus.load && !bus.clr && !bus.clr_all && !reset;
  end

  assign bus.val_a = fwd ? bus.d_in : rd_a;
  assign bus.val_b = bus.mb_select ? imm_b :
                     (fwd && (bus.addr_b == bus.addr_a)) ? bus.d_in : rd_b;
`else
  assign bus.val_a = rd_a;
  assign bus.val_b = bus.mb_select ? imm_b : rd_b;
`endif

  assign bus.busy = (state_q == SWEEP);
  assign bus.done = done_q;
endmodule

// File: tb/tb_param_file_register.sv
// Random + directed bench for param_file_register; two instances (8x8 plain, 6x16 with zero register).
module tb_param_file_register;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, clr, clr_all, load, mb_select;
  logic [2:0]  addr_a, addr_b;
  logic [15:0] d_in;

  param_file_register_if #(.WIDTH(8),  .DEPTH(8)) b0 ();
  param_file_register_if #(.WIDTH(16), .DEPTH(6)) b1 ();

  assign b0.clr = clr;  assign b0.clr_all = clr_all;  assign b0.load = load;
  assign b0.addr_a = addr_a;  assign b0.addr_b = addr_b;  assign b0.mb_select = mb_select;
  assign b0.d_in = d_in[7:0];
  assign b1.clr = clr;  assign b1.clr_all = clr_all;  assign b1.load = load;
  assign b1.addr_a = addr_a;  assign b1.addr_b = addr_b;  assign b1.mb_select = mb_select;
  assign b1.d_in = d_in;

  param_file_register #(.WIDTH(8),  .DEPTH(8), .ZERO_REG(0)) u0 (.clk(clk), .reset(reset), .bus(b0));
  param_file_register #(.WIDTH(16), .DEPTH(6), .ZERO_REG(1)) u1 (.clk(clk), .reset(reset), .bus(b1));

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: contents per instance plus "edges of sweep remaining".
  int dep [2] = '{8, 6};
  int zr  [2] = '{0, 1};
  int msk [2] = '{'hFF, 'hFFFF};
  int mem [2][8];
  int left [2];
  bit dn [2];

  function automatic bit valid(int k, int a);
    return (a < dep[k]) && !(zr[k] != 0 && a == 0);
  endfunction

  function automatic int mread(int k, int a);
    return valid(k, a) ? mem[k][a] : 0;
  endfunction

  function automatic bit fwd(int k);
`ifdef FR_BYPASS_EN
    return left[k] == 0 && load && !clr && !clr_all && !reset && valid(k, int'(addr_a));
`else
    return 1'b0;
`endif
  endfunction

  function automatic int exp_a(int k);
    return fwd(k) ? (int'(d_in) & msk[k]) : mread(k, int'(addr_a));
  endfunction

  function automatic int exp_b(int k);
    if (mb_select) return int'(addr_b) & msk[k];
    if (fwd(k) && addr_b == addr_a) return int'(d_in) & msk[k];
    return mread(k, int'(addr_b));
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        for (int j = 0; j < 8; j++) mem[k][j] = 0;
        left[k] = 0;
        dn[k] = 1'b0;
      end else begin
        bit nd = 1'b0;
        if (left[k] > 0) begin
          mem[k][dep[k] - left[k]] = 0;
          left[k]--;
          nd = (left[k] == 0);
        end else if (clr_all) begin
          left[k] = dep[k];
        end else if (valid(k, int'(addr_a))) begin
          if (clr) mem[k][addr_a] = 0;
          else if (load) mem[k][addr_a] = int'(d_in) & msk[k];
        end
        dn[k] = nd;
      end
    end
  endtask

  task automatic check_outputs();
    check_val("d0_val_a", 32'(b0.val_a), exp_a(0));
    check_val("d0_val_b", 32'(b0.val_b), exp_b(0));
    check_val("d0_busy",  32'(b0.busy), (left[0] > 0) ? 1 : 0);
    check_val("d0_done",  32'(b0.done), 32'(dn[0]));
    check_val("d1_val_a", 32'(b1.val_a), exp_a(1));
    check_val("d1_val_b", 32'(b1.val_b), exp_b(1));
    check_val("d1_busy",  32'(b1.busy), (left[1] > 0) ? 1 : 0);
    check_val("d1_done",  32'(b1.done), 32'(dn[1]));
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit r, input bit ca, input bit c, input bit l,
                       input int aa, input int ab, input int d, input bit mb);
    reset = r; clr_all = ca; clr = c; load = l;
    addr_a = 3'(aa); addr_b = 3'(ab); d_in = 16'(d); mb_select = mb;
  endtask

  task automatic fill();
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 1, i, i, 'h10 + i, 0);
      cycle();
    end
  endtask

  int busy_n0, busy_n1, done_n0, done_n1;

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    model_edge();
    #1;
    cycle();
    check_val("rst_val_a", 32'(b0.val_a), 0);
    check_val("rst_busy", 32'(b0.busy), 0);

    // load A5 to reg 3, observe both ports
    drive(0, 0, 0, 1, 3, 3, 'hA5, 0);
    cycle();
    drive(0, 0, 0, 0, 3, 3, 0, 0);
    check_val("a5_val_a", 32'(b0.val_a), 'hA5);
    check_val("a5_val_b", 32'(b0.val_b), 'hA5);
    cycle();

    drive(0, 0, 0, 0, 3, 6, 0, 1);
    #1 check_val("imm_6", 32'(b0.val_b), 6);
    cycle();

    // sweep with a dropped load on sweep cycle 3
    fill();
    drive(0, 1, 0, 0, 2, 5, 0, 0);
    cycle();
    busy_n0 = 0; busy_n1 = 0; done_n0 = 0; done_n1 = 0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 3) drive(0, 0, 0, 1, 2, 2, 'hFF, 0);
      else        drive(0, 0, 0, 0, c % 8, (c + 3) % 8, 0, 0);
      busy_n0 += int'(b0.busy); busy_n1 += int'(b1.busy);
      done_n0 += int'(b0.done); done_n1 += int'(b1.done);
      cycle();
    end
    check_val("busy_len_d8", busy_n0, 8);
    check_val("busy_len_d6", busy_n1, 6);
    check_val("done_cnt_d8", done_n0, 1);
    check_val("done_cnt_d6", done_n1, 1);
    drive(0, 0, 0, 0, 2, 7, 0, 0);
    #1 check_val("swept_reg2", 32'(b0.val_a), 0);
    check_val("swept_reg7", 32'(b0.val_b), 0);
    cycle();

    // reset during sweep cycle 4, then a load must be accepted
    fill();
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    cycle();
    for (int c = 1; c <= 3; c++) begin drive(0, 0, 0, 0, c, c, 0, 0); cycle(); end
    drive(1, 0, 0, 0, 7, 6, 0, 0);
    cycle();
    drive(0, 0, 0, 1, 4, 7, 'h3C, 0);
    check_val("rst_sweep_busy", 32'(b0.busy), 0);
    check_val("rst_sweep_done", 32'(b0.done), 0);
    check_val("rst_sweep_reg7", 32'(b0.val_b), 0);
    cycle();
    drive(0, 0, 0, 0, 4, 4, 0, 0);
    #1 check_val("post_rst_load", 32'(b0.val_a), 'h3C);
    cycle();

    // zero register, clr beats load, out-of-range address on the 6-deep copy
    drive(0, 0, 0, 1, 0, 0, 'h55, 0); cycle();
    drive(0, 0, 0, 1, 5, 5, 'h33, 0); cycle();
    drive(0, 0, 1, 1, 5, 5, 'h44, 0); cycle();
    drive(0, 0, 0, 1, 7, 7, 'hBEEF, 0); cycle();
    drive(0, 0, 0, 0, 0, 7, 0, 0);
    #1 check_val("zreg_d1", 32'(b1.val_a), 0);
    check_val("oob_d1", 32'(b1.val_b), 0);
    check_val("load7_d0", 32'(b0.val_b), 'hEF);
    cycle();
    drive(0, 0, 0, 0, 5, 0, 0, 0);
    #1 check_val("clr_wins_d1", 32'(b1.val_a), 0);
    cycle();

    // clr_all held high: back-to-back sweeps
    for (int c = 0; c < 20; c++) begin
      drive(0, 1, c[0], 1, c % 8, (c * 3) % 8, c * 37, c[1]);
      cycle();
    end

    for (int c = 0; c < 800; c++) begin
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5,
            $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 60,
            $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 'hFFFF),
            $urandom_range(0, 3) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/param_file_register.md
Name: param_file_register

Overview:
Parametrised successor to the 8x8 datapath register file. Provides DEPTH registers of WIDTH bits, two combinational read ports (A, B) and one synchronous write port on address A. Adds an optional hard-wired zero register and a multi-cycle clear-all sweep FSM with busy/done handshake. A, B and the immediate-select path on B are kept so it drops into the existing single-cycle datapath.

Parameters:
WIDTH, 8, data width of each register and of d_in/val_a/val_b
DEPTH, 8, number of registers (>=2; need not be a power of two)
ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes/clears
AW (localparam), $clog2(DEPTH), address width

Ports:
clk  input  1  single clock; all state changes on its rising edge
reset  input  1  synchronous, active-high; clears all registers, FSM to IDLE
clr  input  1  clear register addr_a at next edge
clr_all  input  1  request sequential sweep clearing all registers
load  input  1  write d_in to register addr_a at next edge
addr_a  input  AW  write/clear address and read port A address
addr_b  input  AW  read port B address / immediate value
d_in  input  WIDTH  write data
mb_select  input  1  1 = val_b is addr_b zero-extended (truncated if AW>WIDTH); 0 = register addr_b
val_a  output  WIDTH  combinational read of register addr_a
val_b  output  WIDTH  combinational read of register addr_b, or immediate
busy  output  1  high while sweep in progress
done  output  1  one-cycle pulse after sweep completes

Behaviour:
- Clock is clk; reset is synchronous and active-high, named reset. Same-edge reset overrides every other input.
- After reset: all registers 0, state IDLE, sweep counter 0, busy=0, done=0; val_a=0; val_b=0, or addr_b when mb_select=1.
- Reads are combinational, zero latency; write effects are visible the cycle after the edge.
- FSM states: IDLE, SWEEP.
- IDLE priority per edge: clr_all > clr > load.
  - clr_all=1: enter SWEEP, counter=0; no register is modified that edge.
  - else clr=1: reg[addr_a] <= 0.
  - else load=1: reg[addr_a] <= d_in.
- SWEEP: each edge clears reg[counter] and increments counter. At counter==DEPTH-1 the edge clears the last register and returns to IDLE.
- busy=1 for exactly DEPTH cycles, equal to state==SWEEP.
- done=1 for exactly the first cycle back in IDLE, registered.
- During SWEEP, load, clr and clr_all are ignored and dropped, not queued. Reads stay live; already-swept registers read 0.
- clr_all held high: a new sweep starts on the edge where done is high, since the FSM is back in IDLE.
- reset mid-sweep: sweep aborts, all registers 0, busy=0, done stays 0.
- Out-of-range address (addr >= DEPTH, non-power-of-two DEPTH): read returns 0; load/clr ignored.
- ZERO_REG=1: reg 0 reads 0 on both ports; load/clr to address 0 has no effect; sweep timing unchanged (still DEPTH cycles).
- Width rules: immediate path zero-extends addr_b to WIDTH, or keeps the low WIDTH bits if AW>WIDTH.

Optional Feature:
FR_BYPASS_EN
- Defined: write-through forwarding. In IDLE with load=1 and clr=0, clr_all=0, reset=0, and the target address valid (and not reg 0 when ZERO_REG=1), val_a returns d_in combinationally in the same cycle. val_b returns d_in when mb_select=0 and addr_b==addr_a.
- Not defined: reads always return the stored pre-edge value.
- Storage update timing is identical in both cases.

Test Plan:
- Reset, then load 8'hA5 to addr 3, read addr_a=3 / addr_b=3 with mb_select=0 -> val_a=val_b=8'hA5 the next cycle; 8'h00 in the load cycle without FR_BYPASS_EN, 8'hA5 with it.
- mb_select=1, addr_b=3'd6 -> val_b=8'h06 regardless of register contents; mb_select=0 -> register 6 contents.
- Fill regs 0..7 with 8'h10..8'h17, pulse clr_all, assert load to reg 2 with 8'hFF on cycle 3 of the sweep -> busy high for 8 cycles; done pulses once on cycle 9; all regs read 0; write dropped.
- Same fill, pulse clr_all, assert reset on sweep cycle 4 -> next cycle busy=0, done=0, all regs 0, state IDLE (load accepted the next cycle).
- ZERO_REG=1: load 8'h55 to addr 0 -> val_a=0. Same cycle: clr=1 and load=1 at addr 5 holding 8'h33 -> reg 5 reads 0 (clr wins).
- DEPTH=6, WIDTH=16: load 16'hBEEF to addr 7 -> ignored; read addr 7 returns 0; sweep busy=6 cycles.
